// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// word/byte widths and the default end-of-program marker.
package program_loader_pkg;
  localparam int INSTR_W = 32;
  localparam int BYTE_W  = 8;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4,
    CHK   = 3'd5
  } loaderState_t;
endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs a big-endian byte stream into 32-bit words; wordReady pulses
// combinationally with the 4th byte so the caller can latch the full word.
module byte_assembler
  import program_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shiftEn,
  input  logic [BYTE_W-1:0]  byteIn,
  output logic [INSTR_W-1:0] word,
  output logic               wordReady
);
  logic [INSTR_W-BYTE_W-1:0] shReg;
  logic [1:0]                byteCnt;

  // only the three bytes already received need storage; the 4th is in flight
  assign word      = {shReg, byteIn};
  assign wordReady = shiftEn && (byteCnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shReg   <= '0;
      byteCnt <= '0;
    end else if (clear) begin
      shReg   <= '0;
      byteCnt <= '0;
    end else if (shiftEn) begin
      shReg   <= word[INSTR_W-BYTE_W-1:0];
      byteCnt <= byteCnt + 2'd1;
    end
  end
endmodule

// File: rtl/program_loader.sv
// Serial-to-instruction-memory loader feeding the fetch stage's program-load port.
// Optional trailing checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned        MAX_WORDS = 1024,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inStart,
  input  logic [BYTE_W-1:0]  inRxData,
  input  logic               inRxDone,
  output logic               outLoadProgram,
  output logic [INSTR_W-1:0] outAddress,
  output logic [INSTR_W-1:0] outData,
  output logic               outWrInstruction,
  output logic               outDone,
  output logic               outError,
  output logic [31:0]        outWordCount
);
  loaderState_t       state, stateNext;
  logic               loadN, wrN, doneN, errN;
  logic [INSTR_W-1:0] addrN, dataN;
  logic [31:0]        cntN;
  logic               idleLike, asmClear, shiftEn, wordReady, haltInWrite;
  logic [INSTR_W-1:0] asmWord;

  assign idleLike    = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign asmClear    = idleLike && inStart;
  assign haltInWrite = (state == WRITE) && (outData == HALT_WORD);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xorReg;
  // a byte landing in the halt-word write cycle is the checksum itself
  assign shiftEn = inRxDone && ((state == RECV) || ((state == WRITE) && !haltInWrite));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           xorReg <= '0;
    else if (asmClear) xorReg <= '0;
    else if (shiftEn)  xorReg <= xorReg ^ inRxData;
  end
`else
  assign shiftEn = inRxDone && ((state == RECV) || (state == WRITE));
`endif

  byte_assembler uAsm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asmClear),
    .shiftEn   (shiftEn),
    .byteIn    (inRxData),
    .word      (asmWord),
    .wordReady (wordReady)
  );

  always_comb begin
    stateNext = state;
    loadN     = outLoadProgram;
    addrN     = outAddress;
    dataN     = outData;
    wrN       = 1'b0;
    doneN     = outDone;
    errN      = outError;
    cntN      = outWordCount;
    case (state)
      IDLE, DONE, ERROR: begin
        if (inStart) begin
          stateNext = RECV;
          addrN     = '0;
          cntN      = '0;
          doneN     = 1'b0;
          errN      = 1'b0;
          loadN     = 1'b1;
        end
      end
      RECV: begin
        if (wordReady) begin
          dataN     = asmWord;
          wrN       = 1'b1;
          stateNext = WRITE;
        end
      end
      WRITE: begin
        cntN = outWordCount + 32'd1;
        if (haltInWrite) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          stateNext = CHK;
          if (inRxDone) begin
            loadN = 1'b0;
            if (inRxData == xorReg) begin stateNext = DONE;  doneN = 1'b1; end
            else                    begin stateNext = ERROR; errN  = 1'b1; end
          end
`else
          stateNext = DONE;
          loadN     = 1'b0;
          doneN     = 1'b1;
`endif
        end else if (outAddress == INSTR_W'(MAX_WORDS - 1)) begin
          stateNext = ERROR;
          loadN     = 1'b0;
          errN      = 1'b1;
        end else begin
          stateNext = RECV;
          addrN     = outAddress + 32'd1;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK: begin
        if (inRxDone) begin
          loadN = 1'b0;
          if (inRxData == xorReg) begin stateNext = DONE;  doneN = 1'b1; end
          else                    begin stateNext = ERROR; errN  = 1'b1; end
        end
      end
`endif
      default: begin
        stateNext = IDLE;
        loadN     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      outLoadProgram   <= 1'b0;
      outAddress       <= '0;
      outData          <= '0;
      outWrInstruction <= 1'b0;
      outDone          <= 1'b0;
      outError         <= 1'b0;
      outWordCount     <= '0;
    end else begin
      state            <= stateNext;
      outLoadProgram   <= loadN;
      outAddress       <= addrN;
      outData          <= dataN;
      outWrInstruction <= wrN;
      outDone          <= doneN;
      outError         <= errN;
      outWordCount     <= cntN;
    end
  end
endmodule
